// File: rtl/phy_pkg.sv
// Shared PHY datapath constants and serializer state encoding.
// Used by the 32->8 serializer and the 8->32 packer.
package phy_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  function automatic byte_t msb_byte(word_t w);
    return w[WORD_W-1 -: BYTE_W];
  endfunction

endpackage

// File: rtl/m32_8_if.sv
// Word-in / byte-out bundle of the 32->8 serializer.
// slave is the serializer side, master the word source and byte sink.
interface m32_8_if;
  import phy_pkg::*;

  word_t data_input;
  logic  valid_input;
  logic  ready_32;
  byte_t data_32_8;
  logic  valid_32_8;

  modport master (
    output data_input,
    output valid_input,
    input  ready_32,
    input  data_32_8,
    input  valid_32_8
  );

  modport slave (
    input  data_input,
    input  valid_input,
    output ready_32,
    output data_32_8,
    output valid_32_8
  );

endinterface

// File: rtl/m32_8_word_fifo.sv
// Synchronous word FIFO, power-of-two DEPTH, no bypass.
// Pointers wrap naturally; full/empty decode from registered count.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk_4f) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/m32_8.sv
// 32->8 byte serializer, MSB first, back-to-back words without bubbles.
// Word FIFO in front; registered byte outputs.
module m32_8 #(
  parameter int DEPTH = 2
) (
  input logic    clk_4f,
  input logic    reset,
  m32_8_if.slave bus
);
  import phy_pkg::*;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       last;
  word_t      head;
  logic [0:0] state;
  logic [1:0] cnt;
  word_t      sreg;
  byte_t      byte_q;
  logic       vld_q;

  assign bus.ready_32   = !full;
  assign bus.data_32_8  = byte_q;
  assign bus.valid_32_8 = vld_q;
  assign push           = bus.valid_input && !full;
  assign last           = (cnt == 2'(BYTES_PER_WORD - 1));

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_4f (clk_4f),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .din    (bus.data_input),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    pop = 1'b0;
    unique case (1'b1)
      (state == IDLE): pop = !empty;
      (state == SEND): pop = last && !empty;
      default:         pop = 1'b0;
    endcase
  end

  // Pop on the last byte keeps the byte stream gap-free.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sreg   <= '0;
      byte_q <= '0;
      vld_q  <= 1'b0;
    end else if (pop) begin
      state  <= SEND;
      cnt    <= '0;
      sreg   <= head;
      byte_q <= msb_byte(head);
      vld_q  <= 1'b1;
    end else if (state == SEND && !last) begin
      cnt    <= cnt + 2'd1;
      sreg   <= sreg << BYTE_W;
      byte_q <= sreg[WORD_W-BYTE_W-1 -: BYTE_W];
      vld_q  <= 1'b1;
    end else begin
      state  <= IDLE;
      cnt    <= '0;
      byte_q <= '0;
      vld_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m32_8.sv
// Scoreboard bench for m32_8: randomized words, byte and word
// reference queues, packer model on the byte stream.
module tb_m32_8;
  import phy_pkg::*;

  logic clk_4f = 1'b0;
  logic reset  = 1'b0;

  m32_8_if bus ();

  m32_8 #(
    .DEPTH (2)
  ) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk_4f = ~clk_4f;

  int    errors = 0;
  int    checks = 0;
  byte_t exp_bytes[$];
  word_t exp_words[$];
  int    run_len = 0;
  int    max_run = 0;
  bit    saw_busy = 1'b0;
  word_t pk_acc = '0;
  int    pk_n = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: byte scoreboard plus an 8->32 packer model.
  always @(negedge clk_4f) begin
    if (reset) begin
      if (!bus.ready_32) saw_busy = 1'b1;
      if (bus.valid_32_8) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_bytes.size() == 0)
          fail("unexpected_byte");
        else
          check("byte", 32'(bus.data_32_8),
                32'(exp_bytes.pop_front()));
        pk_acc = {pk_acc[23:0], bus.data_32_8};
        pk_n++;
        if (pk_n == BYTES_PER_WORD) begin
          pk_n = 0;
          if (exp_words.size() == 0)
            fail("unexpected_word");
          else
            check("word", pk_acc, exp_words.pop_front());
        end
      end else begin
        run_len = 0;
        check("idle_data", 32'(bus.data_32_8), 32'h0);
      end
    end
  end

  // Holds valid until accepted; returns 1ns after the accepting edge.
  task automatic send(input word_t w, output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    bus.valid_input = 1'b1;
    bus.data_input  = w;
    while (!done) begin
      @(negedge clk_4f);
      if (bus.ready_32) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited >= 50) begin
          fail("send_timeout");
          bus.valid_input = 1'b0;
          return;
        end
      end
    end
    exp_words.push_back(w);
    for (int k = 3; k >= 0; k--)
      exp_bytes.push_back(w[k*8 +: 8]);
    @(posedge clk_4f);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || bus.valid_32_8)
           && n < 200) begin
      @(negedge clk_4f);
      n++;
    end
    check("drain", 32'(exp_bytes.size()), 32'h0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wt;
    bus.valid_input = 1'b0;
    bus.data_input  = '0;
    #2;
    check("rst_valid", 32'(bus.valid_32_8), 32'h0);
    check("rst_data", 32'(bus.data_32_8), 32'h0);
    check("rst_ready", 32'(bus.ready_32), 32'h1);
    repeat (2) @(posedge clk_4f);
    #2 reset = 1'b1;
    @(posedge clk_4f);
    #1;

    // Single word: idle cycle, then 4 bytes, then idle.
    max_run = 0;
    send(32'hAABBCCDD, wt);
    bus.valid_input = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_4f);
      check("lat_valid", 32'(bus.valid_32_8),
            32'((k >= 1 && k <= 4) ? 1 : 0));
    end
    check("single_run", 32'(max_run), 32'd4);
    wait_drain();

    // Continuous upstream: 12 bytes without a gap.
    repeat (3) @(posedge clk_4f);
    #1;
    max_run  = 0;
    saw_busy = 1'b0;
    send(32'h01020304, wt);
    send(32'h05060708, wt);
    send(32'h090A0B0C, wt);
    bus.valid_input = 1'b0;
    wait_drain();
    check("cont_run", 32'(max_run), 32'd12);
    check("cont_busy", 32'(saw_busy), 32'h1);

    // Backpressure: fourth word waits 3 cycles.
    repeat (2) @(posedge clk_4f);
    #1;
    send(32'hA1A2A3A4, wt);
    send(32'hB1B2B3B4, wt);
    send(32'hC1C2C3C4, wt);
    send(32'h11223344, wt);
    bus.valid_input = 1'b0;
    check("bp_wait", 32'(wt), 32'd3);
    wait_drain();

    // Reset right after byte BB has been observed.
    repeat (2) @(posedge clk_4f);
    #1;
    send(32'hAABBCCDD, wt);
    bus.valid_input = 1'b0;
    repeat (2) @(posedge clk_4f);
    @(negedge clk_4f);
    #1 reset = 1'b0;
    exp_bytes.delete();
    exp_words.delete();
    pk_n = 0;
    #1;
    check("mid_rst_valid", 32'(bus.valid_32_8), 32'h0);
    check("mid_rst_data", 32'(bus.data_32_8), 32'h0);
    check("mid_rst_ready", 32'(bus.ready_32), 32'h1);
    @(posedge clk_4f);
    #2 reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_4f);
      check("post_rst_valid", 32'(bus.valid_32_8), 32'h0);
    end
    check("post_rst_ready", 32'(bus.ready_32), 32'h1);

    // Pointer wrap: 2*DEPTH+1 words with idle gaps.
    @(posedge clk_4f);
    #1;
    for (int i = 0; i < 5; i++) begin
      send(word_t'($urandom), wt);
      bus.valid_input = 1'b0;
      repeat ($urandom_range(0, 6)) @(posedge clk_4f);
      #1;
    end
    wait_drain();

    // Loopback: 100 random words, random upstream gaps.
    @(posedge clk_4f);
    #1;
    for (int i = 0; i < 100; i++) begin
      send(word_t'($urandom), wt);
      if ($urandom_range(0, 3) == 0) begin
        bus.valid_input = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk_4f);
        #1;
      end
    end
    bus.valid_input = 1'b0;
    wait_drain();
    check("words_left", 32'(exp_words.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
